// File: rtl/server_mcp23s17_pkg.sv
// Shared constants, state encoding and small helpers for the MCP23S17-style
// SPI GPIO expander (server_mcp23s17).
package server_mcp23s17_pkg;

    // Fixed upper nibble of the device opcode (0100_A2A1A0_RW).
    localparam logic [3:0] OPCODE_BASE = 4'b0100;

    // Register map (BANK=0 layout, only the implemented subset).
    localparam logic [7:0] ADDR_IODIRA = 8'h00;
    localparam logic [7:0] ADDR_IODIRB = 8'h01;
    localparam logic [7:0] ADDR_IPOLA  = 8'h02;
    localparam logic [7:0] ADDR_IPOLB  = 8'h03;
    localparam logic [7:0] ADDR_GPIOA  = 8'h12;
    localparam logic [7:0] ADDR_GPIOB  = 8'h13;
    localparam logic [7:0] ADDR_OLATA  = 8'h14;
    localparam logic [7:0] ADDR_OLATB  = 8'h15;
    localparam logic [7:0] ADDR_LAST   = 8'h15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPCODE = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    // Sequential register pointer: wraps from the last mapped address to 0.
    function automatic logic [7:0] next_ptr(input logic [7:0] ptr);
        if (ptr == ADDR_LAST) begin
            next_ptr = 8'h00;
        end else begin
            next_ptr = ptr + 8'h01;
        end
    endfunction

    // Per-bit port view: inputs show (possibly inverted) pins, outputs show the latch.
    function automatic logic [7:0] gpio_view(input logic [7:0] dir, input logic [7:0] pol,
                                             input logic [7:0] pins, input logic [7:0] lat);
        gpio_view = (dir & (pins ^ pol)) | (~dir & lat);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI input, with rise/fall
// detection on the synchronized value. IDLE_LEVEL is the reset value of the
// whole chain so that no spurious edge is reported out of reset.
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Shift the input through the synchronizer and remember the last synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{IDLE_LEVEL}};
            prev_r <= IDLE_LEVEL;
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign dout = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/server_mcp23s17.sv
// SPI slave emulating the core register set of an MCP23S17 16-bit GPIO expander.
// Optional feature: define SERVER_MCP23S17_HAEN_EN to require the opcode's
// A2..A0 field to match HW_ADDR; otherwise any hardware address is accepted.
module server_mcp23s17 import server_mcp23s17_pkg::*; #(
    parameter logic [2:0] HW_ADDR         = 3'b000,
    parameter int         SPI_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [15:0] gpio_dir
);

    logic cs_s, cs_rise_s, cs_fall_s;
    logic unused_sclk_s, sclk_rise_s, sclk_fall_s;
    logic mosi_s, unused_mosi_rise_s, unused_mosi_fall_s;

    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs),
        .dout(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .dout(unused_sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(mosi_s), .rise(unused_mosi_rise_s), .fall(unused_mosi_fall_s)
    );

    state_t      state_r, state_next_s;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r, rx_byte_s;
    logic        byte_done_s, opcode_ok_s;
    logic        rw_r;
    logic [7:0]  ptr_r;
    logic [SPI_SYNC_STAGES:0] settle_r;
    logic        armed_r;
    logic        wr_en_r;
    logic [7:0]  wr_addr_r, wr_data_r;
    logic        load_pending_r;
    logic [7:0]  tx_r, tx_next_s, rd_data_s;
    logic        miso_r;
    logic [15:0] iodir_r, ipol_r, olat_r;

    assign rx_byte_s   = {shift_r[6:0], mosi_s};
    assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7);

`ifdef SERVER_MCP23S17_HAEN_EN
    assign opcode_ok_s = (rx_byte_s[7:4] == OPCODE_BASE) && (rx_byte_s[3:1] == HW_ADDR);
`else
    localparam logic [2:0] unused_hw_addr = HW_ADDR;
    assign opcode_ok_s = (rx_byte_s[7:4] == OPCODE_BASE);
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; chip-select release always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (cs_rise_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s && armed_r) begin
                        state_next_s = OPCODE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                OPCODE: begin
                    if (byte_done_s) begin
                        if (opcode_ok_s) begin
                            state_next_s = ADDR;
                        end else begin
                            state_next_s = IGNORE;
                        end
                    end else begin
                        state_next_s = OPCODE;
                    end
                end
                ADDR: begin
                    if (byte_done_s) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = ADDR;
                    end
                end
                DATA:    state_next_s = DATA;
                IGNORE:  state_next_s = IGNORE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Arm frame detection only once chip select has been seen high after the
    // synchronizers have flushed, so a frame cut by reset is ignored to its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= '0;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[SPI_SYNC_STAGES-1:0], 1'b1};
            armed_r  <= armed_r | (settle_r[SPI_SYNC_STAGES] & cs_s);
        end
    end

    // Receive shifter, bit counter, R/W flag and register pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            rw_r      <= 1'b0;
            ptr_r     <= 8'h00;
        end else begin
            if (state_r == IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if (sclk_rise_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (sclk_rise_s) begin
                shift_r <= rx_byte_s;
            end
            if (state_r == OPCODE && byte_done_s) begin
                rw_r <= rx_byte_s[0];
            end
            if (state_r == ADDR && byte_done_s) begin
                ptr_r <= rx_byte_s;
            end else if (state_r == DATA && byte_done_s) begin
                ptr_r <= next_ptr(ptr_r);
            end
        end
    end

    // Stage a completed write byte; it is committed on the following clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
        end else begin
            wr_en_r   <= (state_r == DATA) && byte_done_s && !rw_r;
            wr_addr_r <= ptr_r;
            wr_data_r <= rx_byte_s;
        end
    end

    // Register file; writing GPIOx lands in the matching output latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iodir_r <= 16'hFFFF;
            ipol_r  <= 16'h0000;
            olat_r  <= 16'h0000;
        end else if (wr_en_r) begin
            case (wr_addr_r)
                ADDR_IODIRA:             iodir_r[7:0]  <= wr_data_r;
                ADDR_IODIRB:             iodir_r[15:8] <= wr_data_r;
                ADDR_IPOLA:              ipol_r[7:0]   <= wr_data_r;
                ADDR_IPOLB:              ipol_r[15:8]  <= wr_data_r;
                ADDR_GPIOA, ADDR_OLATA:  olat_r[7:0]   <= wr_data_r;
                ADDR_GPIOB, ADDR_OLATB:  olat_r[15:8]  <= wr_data_r;
                default: ;
            endcase
        end
    end

    // Read mux for the byte addressed by the pointer; pins sampled when loaded.
    always_comb begin
        rd_data_s = 8'h00;
        case (ptr_r)
            ADDR_IODIRA: rd_data_s = iodir_r[7:0];
            ADDR_IODIRB: rd_data_s = iodir_r[15:8];
            ADDR_IPOLA:  rd_data_s = ipol_r[7:0];
            ADDR_IPOLB:  rd_data_s = ipol_r[15:8];
            ADDR_GPIOA:  rd_data_s = gpio_view(iodir_r[7:0], ipol_r[7:0], gpio_in[7:0], olat_r[7:0]);
            ADDR_GPIOB:  rd_data_s = gpio_view(iodir_r[15:8], ipol_r[15:8], gpio_in[15:8], olat_r[15:8]);
            ADDR_OLATA:  rd_data_s = olat_r[7:0];
            ADDR_OLATB:  rd_data_s = olat_r[15:8];
            default:     rd_data_s = 8'h00;
        endcase
    end

    // Transmit shifter: load after each completed address/data byte of a read, else shift.
    always_comb begin
        tx_next_s = tx_r;
        if (state_r == IDLE) begin
            tx_next_s = 8'h00;
        end else if (sclk_fall_s) begin
            if (load_pending_r) begin
                tx_next_s = rd_data_s;
            end else if (state_r == DATA) begin
                tx_next_s = {tx_r[6:0], 1'b0};
            end else begin
                tx_next_s = tx_r;
            end
        end else begin
            tx_next_s = tx_r;
        end
    end

    // Transmit state and registered MISO, forced low outside a read data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pending_r <= 1'b0;
            tx_r           <= 8'h00;
            miso_r         <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                load_pending_r <= 1'b0;
            end else if (byte_done_s && rw_r && (state_r == ADDR || state_r == DATA)) begin
                load_pending_r <= 1'b1;
            end else if (sclk_fall_s) begin
                load_pending_r <= 1'b0;
            end
            tx_r   <= tx_next_s;
            miso_r <= (state_r == DATA && rw_r && !cs_s) ? tx_next_s[7] : 1'b0;
        end
    end

    assign spi_miso = miso_r;
    assign gpio_out = olat_r;
    assign gpio_dir = iodir_r;

endmodule

// File: tb/tb_server_mcp23s17.sv
// Scoreboard bench for server_mcp23s17: a register-map model predicts every
// MISO byte and the GPIO outputs at the end of each frame; a monitor process
// compares what the DUT presents against those queued predictions.
`timescale 1ns/1ps
module tb_server_mcp23s17;

    localparam logic [2:0] HW   = 3'b001;
    localparam int         HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] gpio_in = 16'h0000;
    logic [15:0] gpio_out, gpio_dir;
    logic        chk_strobe = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_miso_q[$];
    logic [31:0] exp_state_q[$];
    logic [15:0] m_dir, m_pol, m_lat;
    logic [7:0]  fbuf [8];
    logic [7:0]  mon_byte = 8'h00;
    logic [7:0]  mon_exp;
    logic [31:0] mon_state;
    int          mon_bits = 0;

    server_mcp23s17 #(.HW_ADDR(HW), .SPI_SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_dir(gpio_dir)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_read(input int a, input logic [15:0] pins);
        logic [7:0] r;
        int k;
        r = 8'h00;
        case (a)
            0: r = m_dir[7:0];
            1: r = m_dir[15:8];
            2: r = m_pol[7:0];
            3: r = m_pol[15:8];
            18, 19: begin
                for (int i = 0; i < 8; i++) begin
                    k = (a - 18) * 8 + i;
                    r[i] = m_dir[k] ? (pins[k] ^ m_pol[k]) : m_lat[k];
                end
            end
            20: r = m_lat[7:0];
            21: r = m_lat[15:8];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        case (a)
            0: m_dir[7:0]  = d;
            1: m_dir[15:8] = d;
            2: m_pol[7:0]  = d;
            3: m_pol[15:8] = d;
            18, 20: m_lat[7:0]  = d;
            19, 21: m_lat[15:8] = d;
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_dir = 16'hFFFF;
        m_pol = 16'h0000;
        m_lat = 16'h0000;
    endtask

    // ---------------- monitor ----------------
    always @(posedge spi_clk or negedge spi_cs or posedge chk_strobe) begin
        if (chk_strobe) begin
            checks++;
            if (exp_state_q.size() == 0) begin
                errors++;
                $display("FAIL state_queue: got empty queue, required an expectation");
            end else begin
                mon_state = exp_state_q.pop_front();
                if ({gpio_dir, gpio_out} !== mon_state) begin
                    errors++;
                    $display("FAIL gpio_state: got dir=%04h out=%04h, required dir=%04h out=%04h",
                             gpio_dir, gpio_out, mon_state[31:16], mon_state[15:0]);
                end
            end
            checks++;
            if (spi_miso !== 1'b0) begin
                errors++;
                $display("FAIL miso_idle: got %b, required 0", spi_miso);
            end
        end else if (spi_clk) begin
            mon_byte = {mon_byte[6:0], spi_miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                checks++;
                if (exp_miso_q.size() == 0) begin
                    errors++;
                    $display("FAIL miso_queue: got byte %02h with empty queue", mon_byte);
                end else begin
                    mon_exp = exp_miso_q.pop_front();
                    if (mon_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL miso_byte: got %02h, required %02h", mon_byte, mon_exp);
                    end
                end
            end
        end else begin
            mon_bits = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            tick(HALF);
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic state_check();
        exp_state_q.push_back({m_dir, m_lat});
        chk_strobe = 1'b1;
        tick(1);
        chk_strobe = 1'b0;
        tick(1);
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        fbuf[0] = b0; fbuf[1] = b1; fbuf[2] = b2; fbuf[3] = b3;
        for (int k = 4; k < 8; k++) fbuf[k] = 8'h00;
    endtask

    // Predict a frame of n whole bytes (plus tail partial bits), then drive it.
    task automatic frame(input int n, input int tail);
        logic ok;
        logic rw;
        int   ptr;
        ok = (fbuf[0][7:4] == 4'b0100);
`ifdef SERVER_MCP23S17_HAEN_EN
        ok = ok && (fbuf[0][3:1] == HW);
`endif
        rw  = fbuf[0][0];
        ptr = 0;
        for (int k = 0; k < n; k++) begin
            if (ok && k >= 2) begin
                if (rw) begin
                    exp_miso_q.push_back(m_read(ptr, gpio_in));
                end else begin
                    exp_miso_q.push_back(8'h00);
                    m_write(ptr, fbuf[k]);
                end
                ptr = (ptr == 21) ? 0 : (ptr + 1) % 256;
            end else begin
                exp_miso_q.push_back(8'h00);
                if (k == 1) ptr = int'(fbuf[1]);
            end
        end
        spi_cs = 1'b0;
        tick(HALF);
        for (int k = 0; k < n; k++) spi_bits(fbuf[k], 8);
        if (tail > 0) spi_bits(8'($urandom), tail);
        tick(HALF);
        spi_cs = 1'b1;
        tick(10);
        state_check();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        m_reset();
        tick(5);
        rst_n = 1'b1;
        tick(10);
        state_check();                                   // reset values

        set_frame(8'h40, 8'h00, 8'h00, 8'h00); frame(4, 0);   // IODIR = 0
        set_frame(8'h40, 8'h14, 8'hA5, 8'h3C); frame(4, 0);   // OLAT = 3CA5
        set_frame(8'h40, 8'h00, 8'hFF, 8'hFF); frame(4, 0);   // IODIR = FFFF
        set_frame(8'h40, 8'h02, 8'h0F, 8'h00); frame(3, 0);   // IPOLA = 0F
        gpio_in = 16'h12F0;
        set_frame(8'h41, 8'h12, 8'h00, 8'h00); frame(4, 0);   // read FF, 12
        set_frame(8'h40, 8'h15, 8'h77, 8'h00); frame(4, 0);   // wrap write
        set_frame(8'h41, 8'h14, 8'h00, 8'h00); frame(4, 0);   // read OLATA, OLATB
        set_frame(8'h40, 8'h14, 8'hAA, 8'h00); frame(3, 4);   // abort mid-byte
        set_frame(8'h40, 8'h14, 8'hFF, 8'h00); frame(3, 0);   // address 000
        set_frame(8'h42, 8'h14, 8'hFF, 8'h00); frame(3, 0);   // address 001
        set_frame(8'h41, 8'h15, 8'h00, 8'h00); frame(4, 0);   // read across wrap
        set_frame(8'h41, 8'h08, 8'h00, 8'h00); frame(4, 0);   // unmapped reads
        set_frame(8'h80, 8'h14, 8'h00, 8'h00); frame(3, 0);   // bad opcode

        // Reset in the middle of a frame; the remainder must be ignored.
        spi_cs = 1'b0;
        tick(HALF);
        spi_bits(8'h40, 4);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        m_reset();
        tick(5);
        for (int k = 0; k < 3; k++) exp_miso_q.push_back(8'h00);
        spi_bits(8'h40, 8);
        spi_bits(8'h14, 8);
        spi_bits(8'h55, 8);
        tick(HALF);
        spi_cs = 1'b1;
        tick(10);
        state_check();

        // Randomized frames.
        for (int f = 0; f < 50; f++) begin
            int n;
            int tail;
            logic [7:0] op;
            gpio_in = 16'($urandom);
            n  = $urandom_range(1, 6);
            op = {4'b0100, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            fbuf[0] = op;
            fbuf[1] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 21));
            for (int k = 2; k < 8; k++) fbuf[k] = 8'($urandom);
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            frame(n, tail);
        end

        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/server_mcp23s17.md
SERVER_MCP23S17 -- requirements
Module: server_mcp23s17

Interface
REQ-001 SHALL have parameter HW_ADDR, default 3'b000, device hardware address A2..A0.
REQ-002 SHALL have parameter SPI_SYNC_STAGES, default 2, synchronizer depth for spi_cs, spi_clk and spi_mosi.
REQ-003 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port spi_cs, input, 1, chip select, active-low.
REQ-006 SHALL have port spi_clk, input, 1, SPI clock, mode 0, at most clk/8.
REQ-007 SHALL have port spi_mosi, input, 1, serial data from the master, MSB first.
REQ-008 SHALL have port spi_miso, output, 1, serial data to the master, MSB first.
REQ-009 SHALL have port gpio_in, input, 16, pin levels {B[7:0],A[7:0]}.
REQ-010 SHALL have port gpio_out, output, 16, OLAT contents {OLATB,OLATA}.
REQ-011 SHALL have port gpio_dir, output, 16, IODIR contents; 1 = input.

Function
REQ-012 SHALL sample spi_cs, spi_clk and spi_mosi through SPI_SYNC_STAGES flip-flops and detect spi_clk rise/fall on the synchronized signal.
REQ-013 SHALL use states IDLE, OPCODE, ADDR, DATA and IGNORE.
REQ-014 SHALL go IDLE->OPCODE on synchronized spi_cs falling, and to IDLE from any state on synchronized spi_cs rising.
REQ-015 SHALL shift spi_mosi on each synchronized spi_clk rise and evaluate a byte on the 8th rise.
REQ-016 SHALL accept an opcode 0100_A2A1A0_RW; a match goes OPCODE->ADDR, anything else goes to IGNORE until spi_cs rises.
REQ-017 SHALL load the register pointer from the ADDR byte, then enter DATA.
REQ-018 SHALL implement registers IODIRA 0x00, IODIRB 0x01, IPOLA 0x02, IPOLB 0x03, GPIOA 0x12, GPIOB 0x13, OLATA 0x14, OLATB 0x15.
REQ-019 SHALL read all other addresses 0x00..0x15 as 0x00 and ignore writes to them; addresses above 0x15 behave the same.
REQ-020 SHALL commit a write one clk after the 8th rise of each DATA byte, and a GPIOx write SHALL update OLATx.
REQ-021 SHALL return (IODIR ? gpio_in XOR IPOL : OLAT) per bit for a GPIOx read, with gpio_in captured at the load instant.
REQ-022 SHALL load the read byte on the spi_clk fall following the ADDR byte's 8th rise (and after each DATA byte), then shift spi_miso on each later fall.
REQ-023 SHALL advance the pointer after every DATA byte and wrap 0x15->0x00.
REQ-024 SHALL hold spi_miso at 0 whenever spi_cs is high or the state is not DATA-read.
REQ-025 SHALL keep completed writes when spi_cs rises mid-byte, discard the partial byte and leave registers unchanged by it.

Reset
REQ-026 SHALL, while rst_n is low, set IODIR=0xFFFF, IPOL=0x0000, OLAT=0x0000, state IDLE, spi_miso=0 and the synchronizers to idle (cs=1, clk=0).
REQ-027 SHALL, on reset during a frame, ignore the rest of that frame until spi_cs has been seen high.

Configuration
REQ-028 SHALL compare opcode A2..A0 with HW_ADDR when SERVER_MCP23S17_HAEN_EN is defined.
REQ-029 SHALL accept any A2..A0 when SERVER_MCP23S17_HAEN_EN is undefined.

Structure
REQ-030 SHALL place the register address constants, opcode constant 4'b0100 and state enumeration in package server_mcp23s17_pkg.
REQ-031 SHALL place the synchronizer plus edge detector in sub-module spi_sync_edge, instantiated once per SPI input.

Verification
REQ-032 Reset: after rst_n release -> gpio_dir=0xFFFF, gpio_out=0x0000, spi_miso=0.
REQ-033 Frame 0x40,0x00,0x00,0x00 -> gpio_dir=0x0000; frame 0x40,0x14,0xA5,0x3C -> gpio_out=0x3CA5.
REQ-034 Read: gpio_dir=0xFFFF, IPOLA=0x0F, gpio_in=0x12F0, frame 0x41,0x12 -> spi_miso bytes 0xFF, 0x12.
REQ-035 Wrap: frame 0x40,0x15,0x77,0x00 -> OLATB=0x77, IODIRA=0x00.
REQ-036 Abort: frame 0x40,0x14,0xAA then 4 bits, spi_cs high -> OLATA=0xAA, OLATB unchanged.
REQ-037 Address: with SERVER_MCP23S17_HAEN_EN and HW_ADDR=3'b001, frame 0x40,0x14,0xFF -> no change; frame 0x42,0x14,0xFF -> OLATA=0xFF.
